// File: rtl/axi_mux_pkg.sv
// Shared types and index helpers for the N:1 AXI mux write-path scheduler.
package axi_mux_pkg;

    typedef enum logic [0:0] {StIdle, StLock} aw_state_e;

    function automatic int unsigned idx_w(input int unsigned n);
        int unsigned w;
        w = $clog2(n);
        if (w < 1) w = 1;
        return w;
    endfunction

    function automatic int unsigned rr_next(input int unsigned k, input int unsigned n);
        return (k + 1) % n;
    endfunction

    function automatic int unsigned rr_idx(input int unsigned base, input int unsigned off,
                                           input int unsigned n);
        return (base + off) % n;
    endfunction

endpackage

// File: rtl/axi_mux_idx_fifo.sv
// Port-index FIFO that orders W bursts behind their AW handshakes.
module axi_mux_idx_fifo #(
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned WIDTH        = 2,
    parameter bit          FALL_THROUGH = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             valid_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  rd_ptr_q, wr_ptr_q;
    logic [CntW-1:0]  cnt_q;
    logic             bypass, do_push, do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CntW'(DEPTH));
    assign bypass  = FALL_THROUGH && empty_o && push_i;
    assign valid_o = !empty_o || bypass;
    assign head_o  = empty_o ? (bypass ? push_data_i : '0) : mem_q[rd_ptr_q];
    // A bypassed index that retires in its arrival cycle is never stored.
    assign do_push = push_i && (!full_o || pop_i) && !(bypass && pop_i);
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (do_push && !do_pop)      cnt_q <= cnt_q + CntW'(1);
            else if (do_pop && !do_push) cnt_q <= cnt_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/axi_mux_wr_sched.sv
// AXI mux write scheduler: round-robin AW arbitration with lock, W ordering via an
// index FIFO, B routing by port index and per-port outstanding-write limits.
module axi_mux_wr_sched
    import axi_mux_pkg::*;
#(
    parameter int unsigned NoSlvPorts  = 4,
    parameter int unsigned MaxWTrans   = 8,
    parameter int unsigned MaxBTrans   = 8,
    parameter bit          FallThrough = 1'b0,
    localparam int unsigned IdxW       = idx_w(NoSlvPorts)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NoSlvPorts-1:0] slv_aw_valid_i,
    output logic [NoSlvPorts-1:0] slv_aw_ready_o,
    output logic                  mst_aw_valid_o,
    input  logic                  mst_aw_ready_i,
    output logic [IdxW-1:0]       aw_sel_o,
    input  logic [NoSlvPorts-1:0] slv_w_valid_i,
    input  logic [NoSlvPorts-1:0] slv_w_last_i,
    output logic [NoSlvPorts-1:0] slv_w_ready_o,
    output logic                  mst_w_valid_o,
    input  logic                  mst_w_ready_i,
    output logic [IdxW-1:0]       w_sel_o,
    input  logic                  b_valid_i,
    input  logic [IdxW-1:0]       b_port_i,
    output logic                  b_ready_o,
    output logic [NoSlvPorts-1:0] slv_b_valid_o,
    input  logic [NoSlvPorts-1:0] slv_b_ready_i,
    output logic                  err_o,
    output logic                  idle_o
);
    localparam int unsigned CntW = $clog2(MaxBTrans + 1);

    aw_state_e             state_q, state_d;
    logic [IdxW-1:0]       lock_idx_q, lock_idx_d;
    logic [IdxW-1:0]       rr_ptr_q;
    logic [CntW-1:0]       cnt_q [NoSlvPorts];
    logic [CntW-1:0]       cnt_d [NoSlvPorts];
    logic [NoSlvPorts-1:0] eligible, cnt_nz, inc_vec, dec_vec;
    logic                  active, grant_found, aw_hs;
    logic [IdxW-1:0]       grant_idx, cand;
    logic                  fifo_full, fifo_empty, fifo_valid, w_pop;
    logic [IdxW-1:0]       fifo_head;
    logic                  b_port_ok, b_hs, b_cnt_zero;

    // Reset forces every handshake output low, even while inputs stay asserted.
    assign active = !rst_i;

    always_comb begin
        eligible    = '0;
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned p = 0; p < NoSlvPorts; p++) begin
            eligible[p] = slv_aw_valid_i[p] && (cnt_q[p] < CntW'(MaxBTrans));
        end
        for (int unsigned i = 0; i < NoSlvPorts; i++) begin
            cand = IdxW'(rr_idx(32'(rr_ptr_q), i, NoSlvPorts));
            if (!grant_found && eligible[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        lock_idx_d     = lock_idx_q;
        mst_aw_valid_o = 1'b0;
        aw_sel_o       = '0;
        unique case (state_q)
            StIdle: begin
                if (active && grant_found && !fifo_full) begin
                    mst_aw_valid_o = 1'b1;
                    aw_sel_o       = grant_idx;
                    if (!mst_aw_ready_i) begin
                        state_d    = StLock;
                        lock_idx_d = grant_idx;
                    end
                end
            end
            StLock: begin
                mst_aw_valid_o = 1'b1;
                aw_sel_o       = lock_idx_q;
                if (mst_aw_ready_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign aw_hs = mst_aw_valid_o && mst_aw_ready_i;

    always_comb begin
        slv_aw_ready_o = '0;
        if (aw_hs) slv_aw_ready_o[aw_sel_o] = 1'b1;
    end

    axi_mux_idx_fifo #(
        .DEPTH        (MaxWTrans),
        .WIDTH        (IdxW),
        .FALL_THROUGH (FallThrough)
    ) u_idx_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (aw_hs),
        .push_data_i (aw_sel_o),
        .pop_i       (w_pop),
        .head_o      (fifo_head),
        .valid_o     (fifo_valid),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    always_comb begin
        slv_w_ready_o = '0;
        mst_w_valid_o = 1'b0;
        w_sel_o       = '0;
        w_pop         = 1'b0;
        if (fifo_valid) begin
            w_sel_o                  = fifo_head;
            mst_w_valid_o            = slv_w_valid_i[fifo_head];
            slv_w_ready_o[fifo_head] = mst_w_ready_i;
            w_pop = slv_w_valid_i[fifo_head] && mst_w_ready_i && slv_w_last_i[fifo_head];
        end
    end

    // Out-of-range ports are sunk so a misrouted B never stalls the master.
    assign b_port_ok = active && (32'(b_port_i) < NoSlvPorts);
    assign b_ready_o = active && (b_port_ok ? slv_b_ready_i[b_port_i] : 1'b1);
    assign b_hs      = b_valid_i && b_ready_o;

    always_comb begin
        b_cnt_zero = 1'b0;
        if (b_port_ok) b_cnt_zero = (cnt_q[b_port_i] == '0);
    end

    assign err_o = b_hs && (!b_port_ok || b_cnt_zero);

    always_comb begin
        slv_b_valid_o = '0;
        inc_vec       = '0;
        dec_vec       = '0;
        cnt_nz        = '0;
        for (int unsigned p = 0; p < NoSlvPorts; p++) begin
            slv_b_valid_o[p] = b_valid_i && b_port_ok && (b_port_i == IdxW'(p));
            inc_vec[p]       = aw_hs && (aw_sel_o == IdxW'(p));
            dec_vec[p]       = b_hs && b_port_ok && (b_port_i == IdxW'(p)) && (cnt_q[p] != '0);
            cnt_nz[p]        = (cnt_q[p] != '0);
            cnt_d[p]         = cnt_q[p];
            if (inc_vec[p] && !dec_vec[p])      cnt_d[p] = cnt_q[p] + CntW'(1);
            else if (dec_vec[p] && !inc_vec[p]) cnt_d[p] = cnt_q[p] - CntW'(1);
        end
    end

    assign idle_o = fifo_empty && (state_q == StIdle) && (cnt_nz == '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            lock_idx_q <= '0;
            rr_ptr_q   <= '0;
            for (int unsigned p = 0; p < NoSlvPorts; p++) cnt_q[p] <= '0;
        end else begin
            state_q    <= state_d;
            lock_idx_q <= lock_idx_d;
            if (aw_hs) rr_ptr_q <= IdxW'(rr_next(32'(aw_sel_o), NoSlvPorts));
            cnt_q      <= cnt_d;
        end
    end

endmodule

// File: tb/tb_axi_mux_wr_sched.sv
// Bench for axi_mux_wr_sched: per-cycle queue/array reference model plus directed scenarios.
module tb_axi_mux_wr_sched;
    localparam int unsigned N    = 5;
    localparam int unsigned IdxW = 3;
    localparam int unsigned MaxW = 4;
    localparam int unsigned MaxB = 3;

    logic            clk, rst;
    logic [N-1:0]    slv_aw_valid, slv_aw_ready;
    logic            mst_aw_valid, mst_aw_ready;
    logic [IdxW-1:0] aw_sel, w_sel, b_port;
    logic [N-1:0]    slv_w_valid, slv_w_last, slv_w_ready;
    logic            mst_w_valid, mst_w_ready;
    logic            b_valid, b_ready, err, idle;
    logic [N-1:0]    slv_b_valid, slv_b_ready;

    int errors = 0;
    int checks = 0;

    axi_mux_wr_sched #(
        .NoSlvPorts  (N),
        .MaxWTrans   (MaxW),
        .MaxBTrans   (MaxB),
        .FallThrough (1'b0)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .slv_aw_valid_i (slv_aw_valid),
        .slv_aw_ready_o (slv_aw_ready),
        .mst_aw_valid_o (mst_aw_valid),
        .mst_aw_ready_i (mst_aw_ready),
        .aw_sel_o       (aw_sel),
        .slv_w_valid_i  (slv_w_valid),
        .slv_w_last_i   (slv_w_last),
        .slv_w_ready_o  (slv_w_ready),
        .mst_w_valid_o  (mst_w_valid),
        .mst_w_ready_i  (mst_w_ready),
        .w_sel_o        (w_sel),
        .b_valid_i      (b_valid),
        .b_port_i       (b_port),
        .b_ready_o      (b_ready),
        .slv_b_valid_o  (slv_b_valid),
        .slv_b_ready_i  (slv_b_ready),
        .err_o          (err),
        .idle_o         (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: outstanding counts, W-order queue, rr pointer, offered-but-unaccepted AW.
    int cnt_m [N];
    int wq [$];
    int rr_m;
    int pend_m;

    task automatic model_reset();
        for (int i = 0; i < N; i++) cnt_m[i] = 0;
        wq.delete();
        rr_m   = 0;
        pend_m = -1;
    endtask

    always @(negedge clk) begin : model_cmp
        logic         e_awv, e_wv, e_br, e_err, e_idle, aw_hs, b_hs, ok, dec_ok, pop;
        logic [N-1:0] e_awr, e_wr, e_bv;
        int           sel, h, bp, p, busy;
        if (rst) begin
            model_reset();
            e_awv = 1'b0; e_wv = 1'b0; e_br = 1'b0; e_err = 1'b0; e_idle = 1'b1;
            e_awr = '0; e_wr = '0; e_bv = '0; sel = -1; h = -1;
            aw_hs = 1'b0; dec_ok = 1'b0; pop = 1'b0; bp = 0; ok = 1'b0;
        end else begin
            sel = -1;
            if (pend_m >= 0) sel = pend_m;
            else if (wq.size() < MaxW) begin
                for (int i = 0; i < N; i++) begin
                    p = (rr_m + i) % N;
                    if (sel < 0 && slv_aw_valid[p] && cnt_m[p] < MaxB) sel = p;
                end
            end
            e_awv = (sel >= 0);
            aw_hs = e_awv && mst_aw_ready;
            e_awr = aw_hs ? (N'(1) << sel) : '0;
            h = (wq.size() > 0) ? wq[0] : -1;
            e_wv  = (h >= 0) && slv_w_valid[h];
            e_wr  = (h >= 0 && mst_w_ready) ? (N'(1) << h) : '0;
            pop   = (h >= 0) && slv_w_valid[h] && mst_w_ready && slv_w_last[h];
            bp    = int'(b_port);
            ok    = (bp < N);
            e_br  = ok ? slv_b_ready[bp] : 1'b1;
            e_bv  = (b_valid && ok) ? (N'(1) << bp) : '0;
            b_hs  = b_valid && e_br;
            dec_ok = b_hs && ok && (cnt_m[ok ? bp : 0] > 0);
            e_err = b_hs && !dec_ok;
            busy = 0;
            for (int i = 0; i < N; i++) busy += cnt_m[i];
            e_idle = (wq.size() == 0) && (pend_m < 0) && (busy == 0);
        end
        chk("m_aw_valid", 32'(mst_aw_valid), 32'(e_awv));
        chk("m_aw_sel", 32'(aw_sel), (sel >= 0) ? 32'(sel) : 32'd0);
        chk("m_aw_ready", 32'(slv_aw_ready), 32'(e_awr));
        chk("m_w_valid", 32'(mst_w_valid), 32'(e_wv));
        chk("m_w_sel", 32'(w_sel), (h >= 0) ? 32'(h) : 32'd0);
        chk("m_w_ready", 32'(slv_w_ready), 32'(e_wr));
        chk("m_b_ready", 32'(b_ready), 32'(e_br));
        chk("m_b_valid", 32'(slv_b_valid), 32'(e_bv));
        chk("m_err", 32'(err), 32'(e_err));
        chk("m_idle", 32'(idle), 32'(e_idle));
        if (!rst) begin
            if (pop) void'(wq.pop_front());
            if (aw_hs) begin
                wq.push_back(sel);
                cnt_m[sel]++;
                rr_m   = (sel + 1) % N;
                pend_m = -1;
            end else if (e_awv) begin
                pend_m = sel;
            end
            if (dec_ok) cnt_m[bp]--;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        slv_aw_valid = '0; mst_aw_ready = 1'b0; slv_w_valid = '0; slv_w_last = '0;
        mst_w_ready = 1'b0; b_valid = 1'b0; b_port = '0; slv_b_ready = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic rand_inputs();
        slv_aw_valid = N'($urandom);
        mst_aw_ready = ($urandom_range(0, 99) < 60);
        slv_w_valid  = N'($urandom);
        slv_w_last   = N'($urandom & $urandom);
        mst_w_ready  = ($urandom_range(0, 1) == 1);
        b_valid      = ($urandom_range(0, 99) < 40);
        b_port       = ($urandom_range(0, 99) < 85) ? IdxW'($urandom_range(0, N - 1))
                                                    : IdxW'($urandom_range(N, 7));
        slv_b_ready  = N'($urandom);
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        model_reset();
        repeat (3) cyc();
        #2;
        chk("reset_idle", 32'(idle), 32'd1);
        chk("reset_aw_valid", 32'(mst_aw_valid), 32'd0);
        cyc();
        rst = 1'b0;

        // Round robin with all ports requesting and W draining every cycle.
        slv_aw_valid = '1; mst_aw_ready = 1'b1;
        slv_w_valid = '1; slv_w_last = '1; mst_w_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #2;
            chk("rr_valid", 32'(mst_aw_valid), 32'd1);
            chk("rr_sel", 32'(aw_sel), 32'(i % N));
            cyc();
        end

        // Lock holds port 2 while port 0 rises.
        do_reset();
        slv_aw_valid = 5'b00100;
        #2; chk("lock_first", 32'(aw_sel), 32'd2);
        cyc();
        slv_aw_valid = 5'b00101;
        for (int i = 0; i < 4; i++) begin
            #2;
            chk("lock_sel", 32'(aw_sel), 32'd2);
            chk("lock_noready", 32'(slv_aw_ready), 32'd0);
            cyc();
        end
        mst_aw_ready = 1'b1;
        #2; chk("lock_hs", 32'(slv_aw_ready), 32'b00100);
        cyc();
        slv_aw_valid = 5'b00001;
        #2;
        chk("lock_next_sel", 32'(aw_sel), 32'd0);
        chk("lock_next_hs", 32'(slv_aw_ready), 32'b00001);
        cyc();

        // W ordering: p1 (4 beats) then p3 (2 beats), p3 offers data first.
        do_reset();
        mst_aw_ready = 1'b1; mst_w_ready = 1'b1;
        slv_aw_valid = 5'b00010; cyc();
        slv_aw_valid = 5'b01000; cyc();
        slv_aw_valid = '0; slv_w_valid = 5'b01000; slv_w_last = 5'b01000;
        #2;
        chk("w_stall_sel", 32'(w_sel), 32'd1);
        chk("w_stall_valid", 32'(mst_w_valid), 32'd0);
        chk("w_stall_ready", 32'(slv_w_ready), 32'b00010);
        cyc();
        slv_w_valid = 5'b01010;
        for (int b = 0; b < 4; b++) begin
            slv_w_last = (b == 3) ? 5'b01010 : 5'b01000;
            #2;
            chk("w_p1_sel", 32'(w_sel), 32'd1);
            chk("w_p1_valid", 32'(mst_w_valid), 32'd1);
            cyc();
        end
        for (int b = 0; b < 2; b++) begin
            slv_w_last = (b == 1) ? 5'b01000 : 5'b00000;
            #2;
            chk("w_p3_sel", 32'(w_sel), 32'd3);
            chk("w_p3_ready", 32'(slv_w_ready), 32'b01000);
            cyc();
        end
        slv_w_valid = '0;
        #2; chk("w_empty", 32'(mst_w_valid), 32'd0);
        cyc();
        // Fill the W-route FIFO, then check the blocked AW waits for one last beat.
        mst_w_ready = 1'b0; slv_aw_valid = '1;
        for (int i = 0; i < 4; i++) begin
            #2; chk("fill_sel", 32'(aw_sel), 32'((4 + i) % N));
            cyc();
        end
        #2; chk("full_block", 32'(mst_aw_valid), 32'd0);
        cyc();
        slv_w_valid = 5'b10000; slv_w_last = 5'b10000; mst_w_ready = 1'b1;
        #2;
        chk("full_pop_block", 32'(mst_aw_valid), 32'd0);
        chk("full_head", 32'(w_sel), 32'd4);
        cyc();
        slv_w_valid = '0; mst_w_ready = 1'b0;
        #2;
        chk("full_resume", 32'(mst_aw_valid), 32'd1);
        chk("full_resume_sel", 32'(aw_sel), 32'd3);
        cyc();

        // Outstanding-write cap per port and same-cycle inc/dec.
        do_reset();
        slv_w_valid = '1; slv_w_last = '1; mst_w_ready = 1'b1; mst_aw_ready = 1'b1;
        slv_aw_valid = 5'b00001;
        for (int i = 0; i < 3; i++) begin
            #2; chk("blim_accept", 32'(slv_aw_ready), 32'b00001);
            cyc();
        end
        #2;
        chk("blim_hold_valid", 32'(mst_aw_valid), 32'd0);
        chk("blim_hold_ready", 32'(slv_aw_ready), 32'd0);
        cyc();
        b_valid = 1'b1; b_port = 3'd0; slv_b_ready = 5'b00001;
        #2;
        chk("blim_b_ready", 32'(b_ready), 32'd1);
        chk("blim_b_valid", 32'(slv_b_valid), 32'b00001);
        cyc();
        b_valid = 1'b0;
        #2; chk("blim_release", 32'(slv_aw_ready), 32'b00001);
        cyc();
        slv_aw_valid = 5'b00010;
        #2; chk("blim_p1", 32'(aw_sel), 32'd1);
        cyc();
        b_valid = 1'b1; b_port = 3'd1; slv_b_ready = 5'b00010;
        #2;
        chk("incdec_hs", 32'(slv_aw_ready), 32'b00010);
        chk("incdec_err", 32'(err), 32'd0);
        cyc();
        slv_aw_valid = '0;
        #2; chk("incdec_one_left", 32'(err), 32'd0);
        cyc();
        #2; chk("incdec_now_zero", 32'(err), 32'd1);
        cyc();

        // Misrouted and unexpected B responses.
        do_reset();
        b_valid = 1'b1; b_port = 3'd5; slv_b_ready = '0;
        #2;
        chk("badport_ready", 32'(b_ready), 32'd1);
        chk("badport_valid", 32'(slv_b_valid), 32'd0);
        chk("badport_err", 32'(err), 32'd1);
        cyc();
        b_valid = 1'b0;
        #2; chk("err_pulse_end", 32'(err), 32'd0);
        cyc();
        b_valid = 1'b1; b_port = 3'd2; slv_b_ready = '1;
        #2;
        chk("zero_cnt_err", 32'(err), 32'd1);
        chk("zero_cnt_valid", 32'(slv_b_valid), 32'b00100);
        cyc();
        b_valid = 1'b0;
        #2; chk("zero_cnt_idle", 32'(idle), 32'd1);
        cyc();

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            rand_inputs();
            cyc();
        end

        // Reset in the middle of traffic.
        rand_inputs();
        rst = 1'b1;
        #2;
        chk("midrst_aw_valid", 32'(mst_aw_valid), 32'd0);
        chk("midrst_aw_ready", 32'(slv_aw_ready), 32'd0);
        chk("midrst_w_valid", 32'(mst_w_valid), 32'd0);
        chk("midrst_w_ready", 32'(slv_w_ready), 32'd0);
        chk("midrst_b", 32'({b_ready, slv_b_valid}), 32'd0);
        chk("midrst_idle", 32'(idle), 32'd1);
        cyc();
        clear_inputs();
        slv_aw_valid = '1; mst_aw_ready = 1'b1;
        cyc();
        rst = 1'b0;
        #2;
        chk("post_rst_valid", 32'(mst_aw_valid), 32'd1);
        chk("post_rst_sel", 32'(aw_sel), 32'd0);
        cyc();
        clear_inputs();
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
